// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the datapath strobe sequencer: step encodings,
// FSM state constants and the per-step control word table.
package ctrl_seq_pkg;

    localparam logic [1:0] S1 = 2'd0;
    localparam logic [1:0] S2 = 2'd1;
    localparam logic [1:0] S3 = 2'd2;
    localparam logic [1:0] S4 = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic sel_a;
        logic sel_b;
        logic mux;
        logic out_en;
    } ctrl_word_t;

    // Load, shift, combine, flush
    localparam ctrl_word_t STEP_WORD [4] = '{
        '{sel_a: 1'b1, sel_b: 1'b0, mux: 1'b0, out_en: 1'b1},
        '{sel_a: 1'b0, sel_b: 1'b1, mux: 1'b0, out_en: 1'b0},
        '{sel_a: 1'b0, sel_b: 1'b1, mux: 1'b1, out_en: 1'b1},
        '{sel_a: 1'b0, sel_b: 1'b0, mux: 1'b0, out_en: 1'b0}
    };

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational lookup of the control word for one sequencer step.
module ctrl_seq_decode
    import ctrl_seq_pkg::*;
(
    input  logic [1:0] step,
    output ctrl_word_t word
);

    always_comb begin
        word = STEP_WORD[step];
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-channel load/shift/combine/flush strobe sequencer with start/busy/done
// handshake, repeat count, continuous mode, hold and abort.
module ctrl_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int RPT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_cont,
    input  logic [RPT_W-1:0] rep_cnt,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             hold,
    input  logic             abort,
    output logic [N_CH-1:0]  sel_a,
    output logic [N_CH-1:0]  sel_b,
    output logic [N_CH-1:0]  mux,
    output logic [N_CH-1:0]  out_en,
    output logic [1:0]       step,
    output logic             busy,
    output logic             done
);

    logic [0:0]       state_q, state_n;
    logic [1:0]       step_q, step_n;
    logic [RPT_W-1:0] pass_q, pass_n;
    logic [RPT_W-1:0] rep_q, rep_n;
    logic             mode_q, mode_n;
    logic [N_CH-1:0]  en_q, en_n;
    logic             done_n;
    logic [N_CH-1:0]  sel_a_n, sel_b_n, mux_n, out_en_n;
    ctrl_word_t       word;

    // Next-state logic; strobes are derived from the next step so the
    // registered outputs always line up with the step being shown.
    always_comb begin
        state_n = state_q;
        step_n  = step_q;
        pass_n  = pass_q;
        rep_n   = rep_q;
        mode_n  = mode_q;
        en_n    = en_q;
        done_n  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start && !abort) begin
                state_n = ST_RUN;
                step_n  = S1;
                pass_n  = '0;
                rep_n   = rep_cnt;
                mode_n  = mode_cont;
                en_n    = ch_en;
            end
        end else if (abort) begin
            state_n = ST_IDLE;
            step_n  = S1;
            pass_n  = '0;
        end else if (!hold) begin
            if (step_q != S4) begin
                step_n = step_q + 2'd1;
            end else if (mode_q || (pass_q < rep_q)) begin
                step_n = S1;
                if (pass_q != '1) begin
                    pass_n = pass_q + 1'b1;
                end
            end else begin
                state_n = ST_IDLE;
                step_n  = S1;
                pass_n  = '0;
                done_n  = 1'b1;
            end
        end
    end

    ctrl_seq_decode u_decode (
        .step (step_n),
        .word (word)
    );

    always_comb begin
        sel_a_n  = '0;
        sel_b_n  = '0;
        mux_n    = '0;
        out_en_n = '0;
        if (state_n == ST_RUN) begin
            sel_a_n  = {N_CH{word.sel_a}}  & en_n;
            sel_b_n  = {N_CH{word.sel_b}}  & en_n;
            mux_n    = {N_CH{word.mux}}    & en_n;
            out_en_n = {N_CH{word.out_en}} & en_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            step_q  <= S1;
            pass_q  <= '0;
            rep_q   <= '0;
            mode_q  <= 1'b0;
            en_q    <= '0;
            done    <= 1'b0;
            sel_a   <= '0;
            sel_b   <= '0;
            mux     <= '0;
            out_en  <= '0;
        end else begin
            state_q <= state_n;
            step_q  <= step_n;
            pass_q  <= pass_n;
            rep_q   <= rep_n;
            mode_q  <= mode_n;
            en_q    <= en_n;
            done    <= done_n;
            sel_a   <= sel_a_n;
            sel_b   <= sel_b_n;
            mux     <= mux_n;
            out_en  <= out_en_n;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign step = step_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: directed scenarios plus random traffic
// against a run-index reference model.
module tb_ctrl_sequencer;

    localparam int N_CH  = 2;
    localparam int RPT_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             mode_cont;
    logic [RPT_W-1:0] rep_cnt;
    logic [N_CH-1:0]  ch_en;
    logic             hold;
    logic             abort;
    logic [N_CH-1:0]  sel_a, sel_b, mux, out_en;
    logic [1:0]       step;
    logic             busy;
    logic             done;

    typedef struct {
        logic [N_CH-1:0] sel_a;
        logic [N_CH-1:0] sel_b;
        logic [N_CH-1:0] mux;
        logic [N_CH-1:0] out_en;
        logic [1:0]      step;
        logic            busy;
        logic            done;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    int   compared = 0;
    int   mismatched = 0;

    // Reference model: position within the run as a flat cycle index
    bit              m_active = 0;
    int              m_idx = 0;
    int              m_passes = 0;
    bit              m_cont = 0;
    logic [N_CH-1:0] m_en = '0;

    ctrl_sequencer #(.N_CH(N_CH), .RPT_W(RPT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode_cont (mode_cont),
        .rep_cnt   (rep_cnt),
        .ch_en     (ch_en),
        .hold      (hold),
        .abort     (abort),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .mux       (mux),
        .out_en    (out_en),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] wordFor(input int st);
        case (st)
            0:       return 4'b1001;
            1:       return 4'b0100;
            2:       return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit mc, input logic [RPT_W-1:0] rc,
                                 input logic [N_CH-1:0] en, input bit h, input bit ab);
        exp_t x;
        logic [3:0] w;
        @(negedge clk);
        rst = r; start = s; mode_cont = mc; rep_cnt = rc; ch_en = en; hold = h; abort = ab;
        x.done = 1'b0;
        if (!r) begin
            m_active = 0;
        end else if (m_active) begin
            if (ab) begin
                m_active = 0;
            end else if (!h) begin
                m_idx++;
                if (!m_cont && m_idx == m_passes * 4) begin
                    m_active = 0;
                    x.done = 1'b1;
                end
            end
        end else if (s && !ab) begin
            m_active = 1;
            m_idx    = 0;
            m_passes = int'(rc) + 1;
            m_cont   = mc;
            m_en     = en;
        end
        x.busy = m_active;
        x.step = m_active ? 2'(m_idx % 4) : 2'd0;
        w = m_active ? wordFor(m_idx % 4) : 4'b0000;
        x.sel_a  = {N_CH{w[3]}} & m_en;
        x.sel_b  = {N_CH{w[2]}} & m_en;
        x.mux    = {N_CH{w[1]}} & m_en;
        x.out_en = {N_CH{w[0]}} & m_en;
        expq.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic holdCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, '0, '0, 1, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("busy",   32'(busy),   32'(e.busy));
            checkOutput("done",   32'(done),   32'(e.done));
            checkOutput("step",   32'(step),   32'(e.step));
            checkOutput("sel_a",  32'(sel_a),  32'(e.sel_a));
            checkOutput("sel_b",  32'(sel_b),  32'(e.sel_b));
            checkOutput("mux",    32'(mux),    32'(e.mux));
            checkOutput("out_en", 32'(out_en), 32'(e.out_en));
        end
    end

    initial begin
        rst = 1'b0; start = 1'b0; mode_cont = 1'b0; rep_cnt = '0; ch_en = '0; hold = 1'b0; abort = 1'b0;

        // Reset held with start asserted, then a single-pass run on both channels
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 4'd0, 2'b11, 0, 0);
        applyStimulus(1, 1, 0, 4'd0, 2'b11, 0, 0);
        idle(6);

        // Three passes, channel 0 only
        applyStimulus(1, 1, 0, 4'd2, 2'b01, 0, 0);
        idle(15);

        // Hold for three cycles while S3 is shown
        applyStimulus(1, 1, 0, 4'd0, 2'b11, 0, 0);
        idle(2);
        holdCycles(3);
        idle(5);

        // Continuous mode for ten passes, then abort while S2 is shown
        applyStimulus(1, 1, 1, 4'd0, 2'b11, 0, 0);
        idle(41);
        applyStimulus(1, 0, 0, '0, '0, 1, 1);
        idle(3);

        // Start during a run is ignored; start on the done cycle is accepted
        applyStimulus(1, 1, 0, 4'd0, 2'b10, 0, 0);
        idle(1);
        applyStimulus(1, 1, 0, 4'd0, 2'b11, 0, 0);
        idle(2);
        applyStimulus(1, 1, 0, 4'd0, 2'b11, 0, 0);
        idle(6);

        // Reset during S3 of the second pass, then a normal run
        applyStimulus(1, 1, 0, 4'd3, 2'b11, 0, 0);
        idle(6);
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        idle(2);
        applyStimulus(1, 1, 0, 4'd1, 2'b11, 0, 0);
        idle(10);

        // Start together with abort in IDLE stays idle; hold does not block a start
        applyStimulus(1, 1, 0, 4'd0, 2'b11, 0, 1);
        applyStimulus(1, 1, 0, 4'd0, 2'b11, 1, 0);
        idle(6);

        // Maximum repeat count gives sixteen passes
        applyStimulus(1, 1, 0, 4'hF, 2'b10, 0, 0);
        idle(68);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 63) != 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0),
                          RPT_W'($urandom_range(0, 15)),
                          N_CH'($urandom),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 31) == 0));
        end

        @(posedge clk);
        #2;
        checkOutput("queue_drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
